// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I MEM stage. Drives the data bus for loads and stores,
// aligns store lanes, formats load data, stalls upstream while a bus access is open.
// Ports: ex_* from EX/MEM, mem_* to MEM/WB, stall_o/addr_err_o/bus_err_o status,
//        dmem_* request/response bus (req/gnt handshake, rvalid response).
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_write_data,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_reg_write,
  input  logic [1:0]  ex_result_src,
  input  logic [31:0] ex_pc_plus4,
  output logic        mem_reg_write,
  output logic [1:0]  mem_result_src,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_read_data,
  output logic [4:0]  mem_rd_addr,
  output logic [31:0] mem_pc_plus4,
  output logic        stall_o,
  output logic        addr_err_o,
  output logic        bus_err_o,
  output logic        dmem_req,
  input  logic        dmem_gnt,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic        memop;
  logic        f3_ok;
  logic        mis;
  logic        legal;
  logic        tmo_hit;
  logic        req, stall, done, tmo, aerr, wb_en;
  logic [1:0]  a_lo;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  assign a_lo  = ex_alu_result[1:0];
  assign memop = ex_valid & (ex_mem_read | ex_mem_write);

  always_comb begin
    f3_ok = 1'b0;
    unique case (1'b1)
      ex_funct3 == 3'b000: f3_ok = 1'b1;
      ex_funct3 == 3'b001: f3_ok = 1'b1;
      ex_funct3 == 3'b010: f3_ok = 1'b1;
      ex_funct3 == 3'b100: f3_ok = ex_mem_read;
      ex_funct3 == 3'b101: f3_ok = ex_mem_read;
      default:             f3_ok = 1'b0;
    endcase
  end

  assign mis = ((ex_funct3[1:0] == 2'b01) & a_lo[0])
             | ((ex_funct3 == 3'b010) & (|a_lo));
  assign legal   = f3_ok & ~mis;
  assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    aerr    = 1'b0;
    wb_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        wb_en = ex_valid & ex_reg_write & ~memop;
        if (memop & legal) begin
          req     = 1'b1;
          stall   = 1'b1;
          state_d = dmem_gnt ? WAIT_RSP : REQ;
        end else if (memop) begin
          aerr = 1'b1;
        end
      end
      REQ: begin
        req   = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          if (dmem_gnt) state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + 1'b1;
        // A response on the timeout cycle still completes normally.
        if (dmem_rvalid) begin
          done    = 1'b1;
          wb_en   = ex_reg_write;
          state_d = IDLE;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_sel = dmem_rdata[{a_lo, 3'b000} +: 8];
  assign half_sel = a_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_fmt = dmem_rdata;
    unique case (ex_funct3)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {24'd0, byte_sel};
      3'b101:  load_fmt = {16'd0, half_sel};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = ex_write_data;
    if (ex_mem_write) begin
      unique case (ex_funct3)
        3'b000: begin
          dmem_be    = 4'b0001 << a_lo;
          dmem_wdata = {4{ex_write_data[7:0]}};
        end
        3'b001: begin
          dmem_be    = a_lo[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{ex_write_data[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = ex_write_data;
        end
      endcase
    end
  end

  assign dmem_we   = ex_mem_write;
  assign dmem_addr = {ex_alu_result[31:2], 2'b00};

  // Reset forces all control outputs quiet even with a memop presented.
  assign dmem_req      = req & rst_n;
  assign stall_o       = stall & rst_n;
  assign addr_err_o    = aerr & rst_n;
  assign bus_err_o     = tmo & rst_n;
  assign mem_reg_write = wb_en & rst_n;

  assign mem_read_data  = (done & ex_mem_read) ? load_fmt : 32'd0;
  assign mem_result_src = ex_result_src;
  assign mem_alu_result = ex_alu_result;
  assign mem_rd_addr    = ex_rd_addr;
  assign mem_pc_plus4   = ex_pc_plus4;

endmodule
